// File: rtl/ex_stage_pkg.sv
// ex_stage_pkg: shared widths, stall encoding, ALU op and divider encodings for the EX stage.
package ex_stage_pkg;
  localparam int STALL_BUS = 6;
  localparam int ID_TO_EX_WD = 146;
  localparam int EX_TO_MEM_WD = 76;
  localparam int EX_TO_ID_WD = 38;
  localparam logic STOP = 1'b1;
  localparam logic NO_STOP = 1'b0;
  localparam logic [1:0] DIV_NONE = 2'b00;
  localparam logic [1:0] DIV_SIGNED = 2'b10;
  localparam logic [1:0] DIV_UNSIGNED = 2'b11;
  typedef enum logic [3:0] {
    ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3,
    ALU_XOR = 4'd4, ALU_NOR = 4'd5, ALU_SLT = 4'd6, ALU_SLTU = 4'd7,
    ALU_SLL = 4'd8, ALU_SRL = 4'd9, ALU_SRA = 4'd10, ALU_LUI = 4'd11,
    ALU_MFHI = 4'd12, ALU_MFLO = 4'd13
  } alu_op_e;
  typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_e;
  typedef struct packed {
    logic [31:0] pc;
    logic [3:0] alu_op;
    logic [31:0] src1;
    logic [31:0] src2;
    logic data_ram_en;
    logic [3:0] data_ram_wen;
    logic sel_rf_res;
    logic rf_we;
    logic [4:0] rf_waddr;
    logic [31:0] store_data;
    logic [1:0] div_op;
  } id_ex_t;
endpackage

// File: rtl/ex_stage_if.sv
// ex_stage_if: stall/ID input bus and MEM/ID/data-RAM outputs of the EX stage.
interface ex_stage_if;
  import ex_stage_pkg::*;
  logic [STALL_BUS-1:0] stall;
  logic [ID_TO_EX_WD-1:0] id_to_ex_bus;
  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus;
  logic [EX_TO_ID_WD-1:0] ex_to_id_bus;
  logic stallreq_for_ex;
  logic data_sram_en;
  logic [3:0] data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  modport master (
    output stall, id_to_ex_bus,
    input ex_to_mem_bus, ex_to_id_bus, stallreq_for_ex,
    input data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata
  );
  modport slave (
    input stall, id_to_ex_bus,
    output ex_to_mem_bus, ex_to_id_bus, stallreq_for_ex,
    output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata
  );
endinterface

// File: rtl/ex_div.sv
// ex_div: 32-iteration restoring divider (IDLE/BUSY/DONE); only built when EX_DIV_EN is defined.
`ifdef EX_DIV_EN
module ex_div
  import ex_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        signed_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  input  logic        ack_i,
  output logic        idle_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] quotient_o,
  output logic [31:0] remainder_o
);
  div_state_e state_q;
  logic [4:0] cnt_q;
  logic [31:0] rem_q, quo_q, dvs_q, rem_d, quo_d;
  logic qneg_q, rneg_q, ge;
  logic [32:0] r;
  assign r = {rem_q, quo_q[31]};
  assign ge = r >= {1'b0, dvs_q};
  assign rem_d = ge ? r[31:0] - dvs_q : r[31:0];
  assign quo_d = {quo_q[30:0], ge};
  assign idle_o = state_q == DIV_IDLE;
  assign busy_o = state_q == DIV_BUSY;
  assign done_o = busy_o && cnt_q == 5'd31;
  // Final step results are taken straight from the last iteration so HI/LO load on the DONE edge.
  assign quotient_o = qneg_q ? -quo_d : quo_d;
  assign remainder_o = rneg_q ? -rem_d : rem_d;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= DIV_IDLE;
      cnt_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
    end else
      case (state_q)
        DIV_IDLE: if (start_i) begin
          state_q <= DIV_BUSY;
          cnt_q <= '0;
          rem_q <= '0;
          quo_q <= signed_i && dividend_i[31] ? -dividend_i : dividend_i;
          dvs_q <= signed_i && divisor_i[31] ? -divisor_i : divisor_i;
          qneg_q <= signed_i && (dividend_i[31] ^ divisor_i[31]);
          rneg_q <= signed_i && dividend_i[31];
        end
        DIV_BUSY: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_q <= DIV_DONE;
        end
        DIV_DONE: if (ack_i) state_q <= DIV_IDLE;
        default: state_q <= DIV_IDLE;
      endcase
endmodule
`endif

// File: rtl/ex_stage.sv
// ex_stage: pipeline EX stage (ALU, data RAM request, forwarding); EX_DIV_EN adds divider and HI/LO.
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic clk,
  input  logic rst,
  ex_stage_if.slave ex_if
);
  id_ex_t r_q;
  logic [31:0] res, hi, lo;
  logic unused_stall;
  assign unused_stall = ^{ex_if.stall[5:4], ex_if.stall[1:0]};
  always_ff @(posedge clk or posedge rst)
    if (rst) r_q <= '0;
    else if (ex_if.stall[2] == NO_STOP) r_q <= ex_if.id_to_ex_bus;
    else if (ex_if.stall[3] != STOP) r_q <= '0;
  always_comb begin
    res = '0;
    case (r_q.alu_op)
      ALU_ADD:  res = r_q.src1 + r_q.src2;
      ALU_SUB:  res = r_q.src1 - r_q.src2;
      ALU_AND:  res = r_q.src1 & r_q.src2;
      ALU_OR:   res = r_q.src1 | r_q.src2;
      ALU_XOR:  res = r_q.src1 ^ r_q.src2;
      ALU_NOR:  res = ~(r_q.src1 | r_q.src2);
      ALU_SLT:  res = {31'b0, $signed(r_q.src1) < $signed(r_q.src2)};
      ALU_SLTU: res = {31'b0, r_q.src1 < r_q.src2};
      ALU_SLL:  res = r_q.src2 << r_q.src1[4:0];
      ALU_SRL:  res = r_q.src2 >> r_q.src1[4:0];
      ALU_SRA:  res = $signed(r_q.src2) >>> r_q.src1[4:0];
      ALU_LUI:  res = {r_q.src2[15:0], 16'b0};
      ALU_MFHI: res = hi;
      ALU_MFLO: res = lo;
      default:  res = '0;
    endcase
  end
`ifdef EX_DIV_EN
  logic div_idle, div_busy, div_done;
  logic [31:0] quo, rem, hi_q, lo_q;
  ex_div u_div (
    .clk(clk),
    .rst(rst),
    .start_i(r_q.div_op[1]),
    .signed_i(~r_q.div_op[0]),
    .dividend_i(r_q.src1),
    .divisor_i(r_q.src2),
    .ack_i(ex_if.stall[2] == NO_STOP),
    .idle_o(div_idle),
    .busy_o(div_busy),
    .done_o(div_done),
    .quotient_o(quo),
    .remainder_o(rem)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (div_done) begin
      hi_q <= rem;
      lo_q <= quo;
    end
  assign hi = hi_q;
  assign lo = lo_q;
  assign ex_if.stallreq_for_ex = (div_idle && r_q.div_op[1]) || div_busy;
`else
  logic unused_div;
  assign unused_div = ^r_q.div_op;
  assign hi = '0;
  assign lo = '0;
  assign ex_if.stallreq_for_ex = 1'b0;
`endif
  assign ex_if.ex_to_mem_bus = {r_q.pc, r_q.data_ram_en, r_q.data_ram_wen, r_q.sel_rf_res,
                                r_q.rf_we, r_q.rf_waddr, res};
  assign ex_if.ex_to_id_bus = {r_q.rf_we, r_q.rf_waddr, res};
  assign ex_if.data_sram_en = r_q.data_ram_en;
  assign ex_if.data_sram_wen = r_q.data_ram_wen;
  assign ex_if.data_sram_addr = res;
  assign ex_if.data_sram_wdata = r_q.store_data;
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed checks of ex_stage; divider expectations follow EX_DIV_EN.
module tb_ex_stage;
  import ex_stage_pkg::*;
`ifdef EX_DIV_EN
  localparam bit DIV_ON = 1'b1;
`else
  localparam bit DIV_ON = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [5:0] stall_tb = '0;
  logic [145:0] bus_tb = '0;
  int errors = 0;
  int checks = 0;
  ex_stage_if ex_if ();
  assign ex_if.stall = stall_tb | (ex_if.stallreq_for_ex ? 6'b000111 : 6'b000000);
  assign ex_if.id_to_ex_bus = bus_tb;
  ex_stage dut (.clk(clk), .rst(rst), .ex_if(ex_if));
  always #5 clk = ~clk;

  function automatic logic [145:0] mk(input logic [31:0] pc, input logic [3:0] op,
      input logic [31:0] s1, input logic [31:0] s2, input logic en, input logic [3:0] wen,
      input logic sel, input logic we, input logic [4:0] wa, input logic [31:0] sd,
      input logic [1:0] dop);
    return {pc, op, s1, s2, en, wen, sel, we, wa, sd, dop};
  endfunction

  function automatic logic [145:0] alu(input logic [3:0] op, input logic [31:0] s1,
      input logic [31:0] s2);
    return mk(32'hBFC00000, op, s1, s2, 1'b0, 4'h0, 1'b0, 1'b1, 5'd1, 32'h0, DIV_NONE);
  endfunction

  task automatic issue(input logic [145:0] b);
    bus_tb = b;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    bus_tb = alu(ALU_ADD, 32'h1, 32'h2);
    repeat (2) @(negedge clk);
    checks += 4;
    if (ex_if.ex_to_mem_bus !== 76'h0) begin
      errors++; $display("FAIL reset ex_to_mem got %h want 0", ex_if.ex_to_mem_bus);
    end
    if (ex_if.ex_to_id_bus !== 38'h0) begin
      errors++; $display("FAIL reset ex_to_id got %h want 0", ex_if.ex_to_id_bus);
    end
    if (ex_if.stallreq_for_ex !== 1'b0) begin
      errors++; $display("FAIL reset stallreq got %b want 0", ex_if.stallreq_for_ex);
    end
    if ({ex_if.data_sram_en, ex_if.data_sram_wen, ex_if.data_sram_wdata} !== 37'h0) begin
      errors++; $display("FAIL reset sram got %b/%h/%h want 0", ex_if.data_sram_en,
                         ex_if.data_sram_wen, ex_if.data_sram_wdata);
    end
    rst = 1'b0;
  endtask

  typedef struct packed {logic [3:0] op; logic [31:0] a; logic [31:0] b; logic [31:0] e;} alu_vec_t;

  task automatic test_alu;
    alu_vec_t v [17];
    v = '{
      '{ALU_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000},
      '{ALU_SUB,  32'h00000000, 32'h00000001, 32'hFFFFFFFF},
      '{ALU_AND,  32'h0000F0F0, 32'h0000FF00, 32'h0000F000},
      '{ALU_OR,   32'h0000F0F0, 32'h0000FF00, 32'h0000FFF0},
      '{ALU_XOR,  32'h0000F0F0, 32'h0000FF00, 32'h00000FF0},
      '{ALU_NOR,  32'h0000F0F0, 32'hFFFF0000, 32'h00000F0F},
      '{ALU_SLT,  32'hFFFFFFFF, 32'h00000001, 32'h00000001},
      '{ALU_SLTU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000},
      '{ALU_SLL,  32'h00000004, 32'h00000001, 32'h00000010},
      '{ALU_SLL,  32'h00000024, 32'h00000001, 32'h00000010},
      '{ALU_SRL,  32'h00000004, 32'h80000000, 32'h08000000},
      '{ALU_SRA,  32'h00000004, 32'h80000000, 32'hF8000000},
      '{ALU_LUI,  32'h0000FFFF, 32'h00001234, 32'h12340000},
      '{ALU_MFHI, 32'h00000005, 32'h00000003, 32'h00000000},
      '{ALU_MFLO, 32'h00000005, 32'h00000003, 32'h00000000},
      '{4'd14,    32'h00000005, 32'h00000003, 32'h00000000},
      '{4'd15,    32'h00000005, 32'h00000003, 32'h00000000}
    };
    for (int i = 0; i < 17; i++) begin
      issue(alu(v[i].op, v[i].a, v[i].b));
      checks += 2;
      if (ex_if.ex_to_mem_bus !== {32'hBFC00000, 1'b0, 4'h0, 1'b0, 1'b1, 5'd1, v[i].e}) begin
        errors++; $display("FAIL alu[%0d] ex_to_mem got %h want result %h", i,
                           ex_if.ex_to_mem_bus, v[i].e);
      end
      if (ex_if.ex_to_id_bus !== {1'b1, 5'd1, v[i].e}) begin
        errors++; $display("FAIL alu[%0d] ex_to_id got %h want result %h", i,
                           ex_if.ex_to_id_bus, v[i].e);
      end
    end
  endtask

  task automatic test_store;
    issue(mk(32'hBFC00010, ALU_ADD, 32'hF0, 32'h10, 1'b1, 4'hF, 1'b0, 1'b0, 5'd0, 32'hAA, DIV_NONE));
    checks += 5;
    if (ex_if.data_sram_en !== 1'b1) begin
      errors++; $display("FAIL store en got %b want 1", ex_if.data_sram_en);
    end
    if (ex_if.data_sram_wen !== 4'hF) begin
      errors++; $display("FAIL store wen got %h want f", ex_if.data_sram_wen);
    end
    if (ex_if.data_sram_addr !== 32'h100) begin
      errors++; $display("FAIL store addr got %h want 00000100", ex_if.data_sram_addr);
    end
    if (ex_if.data_sram_wdata !== 32'hAA) begin
      errors++; $display("FAIL store wdata got %h want 000000aa", ex_if.data_sram_wdata);
    end
    if (ex_if.ex_to_mem_bus !== {32'hBFC00010, 1'b1, 4'hF, 1'b0, 1'b0, 5'd0, 32'h100}) begin
      errors++; $display("FAIL store ex_to_mem got %h", ex_if.ex_to_mem_bus);
    end
  endtask

  task automatic test_stall;
    issue(alu(ALU_ADD, 32'h1, 32'h2));
    stall_tb = 6'b000100;
    issue(alu(ALU_ADD, 32'h5, 32'h5));
    checks += 2;
    if (ex_if.ex_to_mem_bus !== 76'h0) begin
      errors++; $display("FAIL bubble ex_to_mem got %h want 0", ex_if.ex_to_mem_bus);
    end
    if (ex_if.ex_to_id_bus !== 38'h0) begin
      errors++; $display("FAIL bubble ex_to_id got %h want 0", ex_if.ex_to_id_bus);
    end
    stall_tb = 6'b000000;
    issue(alu(ALU_ADD, 32'h1, 32'h2));
    stall_tb = 6'b001100;
    issue(alu(ALU_ADD, 32'h5, 32'h5));
    checks++;
    if (ex_if.ex_to_id_bus !== {1'b1, 5'd1, 32'h3}) begin
      errors++; $display("FAIL hold ex_to_id got %h want %h", ex_if.ex_to_id_bus, {1'b1, 5'd1, 32'h3});
    end
    stall_tb = 6'b000000;
    issue(alu(ALU_ADD, 32'h5, 32'h5));
    checks++;
    if (ex_if.ex_to_id_bus !== {1'b1, 5'd1, 32'hA}) begin
      errors++; $display("FAIL release ex_to_id got %h want %h", ex_if.ex_to_id_bus, {1'b1, 5'd1, 32'hA});
    end
  endtask

  typedef struct packed {logic [1:0] dop; logic [31:0] a; logic [31:0] b; logic [31:0] lo; logic [31:0] hi;} div_vec_t;

  task automatic test_div;
    div_vec_t v [7];
    int n;
    v = '{
      '{DIV_SIGNED,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 32'hFFFFFFFF},
      '{DIV_UNSIGNED, 32'd100,      32'h00000000, 32'hFFFFFFFF, 32'd100},
      '{DIV_UNSIGNED, 32'd100,      32'd7,        32'd14,       32'd2},
      '{DIV_SIGNED,   32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001},
      '{DIV_SIGNED,   32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000},
      '{DIV_SIGNED,   32'hFFFFFFF9, 32'h00000000, 32'h00000001, 32'hFFFFFFF9},
      '{2'b01,        32'd50,       32'd5,        32'h00000001, 32'hFFFFFFF9}
    };
    for (int i = 0; i < 7; i++) begin
      bus_tb = mk(32'hBFC00100, ALU_ADD, v[i].a, v[i].b, 1'b0, 4'h0, 1'b0, 1'b0, 5'd0, 32'h0, v[i].dop);
      @(posedge clk);
      @(negedge clk);
      bus_tb = alu(ALU_MFLO, 32'h0, 32'h0);
      n = 0;
      while (ex_if.stallreq_for_ex && n < 100) begin
        n++;
        @(posedge clk);
        @(negedge clk);
      end
      checks++;
      if (n !== ((DIV_ON && v[i].dop[1]) ? 33 : 0)) begin
        errors++; $display("FAIL div[%0d] stallreq cycles got %0d want %0d", i, n,
                           (DIV_ON && v[i].dop[1]) ? 33 : 0);
      end
      issue(alu(ALU_MFLO, 32'h0, 32'h0));
      checks++;
      if (ex_if.ex_to_id_bus[31:0] !== (DIV_ON ? v[i].lo : 32'h0)) begin
        errors++; $display("FAIL div[%0d] mflo got %h want %h", i, ex_if.ex_to_id_bus[31:0],
                           DIV_ON ? v[i].lo : 32'h0);
      end
      issue(alu(ALU_MFHI, 32'h0, 32'h0));
      checks++;
      if (ex_if.ex_to_id_bus[31:0] !== (DIV_ON ? v[i].hi : 32'h0)) begin
        errors++; $display("FAIL div[%0d] mfhi got %h want %h", i, ex_if.ex_to_id_bus[31:0],
                           DIV_ON ? v[i].hi : 32'h0);
      end
    end
  endtask

  task automatic test_rst_mid_div;
    bus_tb = mk(32'hBFC00200, ALU_ADD, 32'd100, 32'd3, 1'b0, 4'h0, 1'b0, 1'b0, 5'd0, 32'h0, DIV_SIGNED);
    @(posedge clk);
    @(negedge clk);
    bus_tb = alu(ALU_MFLO, 32'h0, 32'h0);
    repeat (11) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checks++;
    if (ex_if.stallreq_for_ex !== 1'b0) begin
      errors++; $display("FAIL midrst stallreq got %b want 0", ex_if.stallreq_for_ex);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (ex_if.stallreq_for_ex !== 1'b0) begin
      errors++; $display("FAIL postrst stallreq got %b want 0", ex_if.stallreq_for_ex);
    end
    issue(alu(ALU_MFLO, 32'h0, 32'h0));
    checks++;
    if (ex_if.ex_to_id_bus[31:0] !== 32'h0) begin
      errors++; $display("FAIL midrst mflo got %h want 0", ex_if.ex_to_id_bus[31:0]);
    end
    issue(alu(ALU_MFHI, 32'h0, 32'h0));
    checks++;
    if (ex_if.ex_to_id_bus[31:0] !== 32'h0) begin
      errors++; $display("FAIL midrst mfhi got %h want 0", ex_if.ex_to_id_bus[31:0]);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_store();
    test_stall();
    test_div();
    test_rst_mid_div();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have parameters: none; all widths come from the shared defines (StallBus=6, ID_TO_EX_WD=146, EX_TO_MEM_WD=76).
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 stall  in  StallBus  pipeline stall vector; Stop=1; bit 2 holds EX, bit 3 holds MEM.
REQ-005 id_to_ex_bus  in  146  {pc[145:114], alu_op[113:110], src1[109:78], src2[77:46], data_ram_en[45], data_ram_wen[44:41], sel_rf_res[40], rf_we[39], rf_waddr[38:34], store_data[33:2], div_op[1:0]}.
REQ-006 ex_to_mem_bus  out  76  {pc, data_ram_en, data_ram_wen, sel_rf_res, rf_we, rf_waddr, ex_result}, MSB first.
REQ-007 ex_to_id_bus  out  38  {rf_we, rf_waddr, ex_result} forwarding path.
REQ-008 stallreq_for_ex  out  1  request to stall IF/ID/EX while divide in progress.
REQ-009 data_sram_en / data_sram_wen[3:0] / data_sram_addr[31:0] / data_sram_wdata[31:0]  out  data RAM request.

Function
REQ-010 Input register SHALL load id_to_ex_bus when stall[2]=NoStop; load zero bubble when stall[2]=Stop and stall[3]=NoStop; otherwise hold.
REQ-011 alu_op: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT (signed), 7 SLTU, 8 SLL, 9 SRL, 10 SRA, 11 LUI (src2<<16), 12 MFHI, 13 MFLO; 14-15 yield 0.
REQ-012 Shifts SHALL shift src2 by src1[4:0]; ADD/SUB wrap modulo 2^32, no trap.
REQ-013 ex_result combinational from registered operands; zero-latency to ex_to_mem_bus, ex_to_id_bus, data_sram_addr.
REQ-014 data_sram_en=data_ram_en, data_sram_wen=data_ram_wen, data_sram_wdata=store_data, all from register.
REQ-015 div_op: 00 none, 10 DIV signed, 11 DIVU, 01 treated as none; quotient->LO, remainder->HI.
REQ-016 Divider FSM states IDLE, BUSY, DONE; IDLE->BUSY when div_op[1]=1 in IDLE; BUSY for exactly 32 iterations; BUSY->DONE; DONE->IDLE when stall[2]=NoStop.
REQ-017 stallreq_for_ex SHALL be 1 in IDLE with div_op[1]=1 and throughout BUSY, 0 in DONE: exactly 33 cycles per divide.
REQ-018 HI/LO SHALL be written once, on the edge entering DONE; MFHI/MFLO in the next EX instruction see new values.
REQ-019 Signed DIV: divide magnitudes; quotient negative iff signs differ; remainder sign follows dividend.
REQ-020 Divide by zero: LO=0xFFFFFFFF, HI=dividend (DIVU); for DIV, same magnitude rule then REQ-019 sign fix; no exception.
REQ-021 MFHI/MFLO in the instruction following a divide SHALL never observe stale HI/LO (guaranteed by REQ-017/018).

Reset
REQ-022 On rst: input register zero, FSM IDLE, HI=LO=0, iteration counter 0; hence all outputs 0, stallreq_for_ex=0.
REQ-023 rst asserted mid-divide SHALL abort immediately; HI/LO stay 0; no partial write.

Configuration
REQ-024 Macro EX_DIV_EN: defined -> divider, HI/LO, MFHI/MFLO as above; undefined -> no divider, div_op ignored, stallreq_for_ex tied 0, MFHI/MFLO return 0.

Structure
REQ-025 StallBus, ID_TO_EX_WD, EX_TO_MEM_WD, Stop/NoStop, alu_op and div_op encodings SHALL live in lib/defines.vh.
REQ-026 Divider SHALL be sub-module ex_div (start, signed, operands, busy/done, quotient, remainder); HI/LO in ex_stage.

Verification
REQ-027 ADD src1=0x7FFFFFFF, src2=1 -> ex_result=0x80000000; SLT 0xFFFFFFFF,1 -> 1; SLTU same -> 0.
REQ-028 SRA src1=4, src2=0x80000000 -> 0xF8000000; LUI src2=0x1234 -> 0x12340000.
REQ-029 DIV -7/2 -> stallreq high 33 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF; following MFLO -> 0xFFFFFFFD.
REQ-030 DIVU 100/0 -> LO=0xFFFFFFFF, HI=100 after 33 cycles.
REQ-031 Store with data_ram_wen=0xF, src1+src2=0x100, store_data=0xAA -> data_sram_en=1, addr=0x100, wdata=0xAA same cycle.
REQ-032 rst pulsed at BUSY iteration 10 -> stallreq 0, HI=LO=0, FSM IDLE; stall[2]=1,stall[3]=0 -> bubble (ex_to_mem_bus=0).
